// File: rtl/uart_alu_ctrl_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// uart_alu_ctrl_if : UART rx/tx handshakes and ALU operand/result bundle
// Rev 1.0
// -----------------------------------------------------------------------------
interface uart_alu_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 6
);
  logic                  i_rx_done;
  logic [DATA_WIDTH-1:0] i_rx_data;
  logic [DATA_WIDTH-1:0] i_alu_result;
  logic                  i_tx_done;
  logic [DATA_WIDTH-1:0] o_alu_a;
  logic [DATA_WIDTH-1:0] o_alu_b;
  logic [OP_WIDTH-1:0]   o_alu_op;
  logic [DATA_WIDTH-1:0] o_tx_data;
  logic                  o_tx_start;
  logic                  o_busy;
  logic                  o_timeout;
  logic                  o_drop;

  modport slave (
    input  i_rx_done, i_rx_data, i_alu_result, i_tx_done,
    output o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_timeout, o_drop
  );

  modport master (
    output i_rx_done, i_rx_data, i_alu_result, i_tx_done,
    input  o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_timeout, o_drop
  );
endinterface
`default_nettype wire

// File: rtl/uart_alu_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// uart_alu_ctrl : collects A/B/opcode bytes, runs the ALU, hands result to TX
// Rev 1.0
// -----------------------------------------------------------------------------
module uart_alu_ctrl #(
  parameter int          DATA_WIDTH = 8,
  parameter int          OP_WIDTH   = 6,
  parameter int unsigned TIMEOUT    = 1000000
) (
  input  logic           clk,
  input  logic           rst,
  uart_alu_ctrl_if.slave bus
);

  localparam int          CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned c_LIMIT_INT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] c_LIMIT = c_LIMIT_INT[CNT_W-1:0];
  localparam bit          c_TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_GET_A   = 3'd0,
    S_GET_B   = 3'd1,
    S_GET_OP  = 3'd2,
    S_EXEC    = 3'd3,
    S_WAIT_TX = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d;
  logic                  busy_q, busy_d;
  logic                  timeout_q, timeout_d;
  logic                  drop_q, drop_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  w_expired;

  assign w_expired = c_TIMEOUT_EN && (cnt_q == c_LIMIT);

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    timeout_d  = 1'b0;
    drop_d     = 1'b0;
    cnt_d      = '0;

    case (state_q)
      S_GET_A: begin
        if (bus.i_rx_done) begin
          a_d     = bus.i_rx_data;
          state_d = S_GET_B;
        end
      end
      S_GET_B: begin
        // A byte landing on the expiry cycle wins over the timeout.
        if (bus.i_rx_done) begin
          b_d     = bus.i_rx_data;
          state_d = S_GET_OP;
        end else if (w_expired) begin
          timeout_d = 1'b1;
          state_d   = S_GET_A;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GET_OP: begin
        if (bus.i_rx_done) begin
          op_d    = bus.i_rx_data[OP_WIDTH-1:0];
          state_d = S_EXEC;
        end else if (w_expired) begin
          timeout_d = 1'b1;
          state_d   = S_GET_A;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EXEC: begin
        tx_data_d  = bus.i_alu_result;
        tx_start_d = 1'b1;
        drop_d     = bus.i_rx_done;
        state_d    = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        drop_d = bus.i_rx_done;
        if (bus.i_tx_done) begin
          state_d = S_GET_A;
        end
      end
      default: state_d = S_GET_A;
    endcase

    busy_d = (state_d == S_EXEC) || (state_d == S_WAIT_TX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_GET_A;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      drop_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.o_alu_a    = a_q;
  assign bus.o_alu_b    = b_q;
  assign bus.o_alu_op   = op_q;
  assign bus.o_tx_data  = tx_data_q;
  assign bus.o_tx_start = tx_start_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_timeout  = timeout_q;
  assign bus.o_drop     = drop_q;

endmodule
`default_nettype wire

// File: doc/uart_alu_ctrl.md
# uart_alu_ctrl

Frame controller between the UART receiver/transmitter pair and the ALU. It collects three received bytes in order: operand A, operand B, then opcode. It drives them onto the ALU, captures the ALU result and hands it to the UART transmitter with a single-cycle start pulse. An inter-byte timeout discards partial frames so a lost byte cannot desynchronise the operand order.

## Interface
- DATA_WIDTH, 8: width of operands, result and UART byte.
- OP_WIDTH, 6: ALU opcode width; taken from the low OP_WIDTH bits of the third byte.
- TIMEOUT, 1000000: max clk cycles allowed between bytes of one frame; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_rx_done  in  1  single-cycle pulse from the UART receiver: byte valid.
- i_rx_data  in  DATA_WIDTH  received byte; sampled only when i_rx_done=1.
- i_alu_result  in  DATA_WIDTH  combinational ALU output.
- i_tx_done  in  1  single-cycle pulse from the UART transmitter: byte fully sent.
- o_alu_a  out  DATA_WIDTH  registered operand A.
- o_alu_b  out  DATA_WIDTH  registered operand B.
- o_alu_op  out  OP_WIDTH  registered opcode.
- o_tx_data  out  DATA_WIDTH  registered result to transmit.
- o_tx_start  out  1  single-cycle transmit request.
- o_busy  out  1  high in states EXEC and WAIT_TX.
- o_timeout  out  1  single-cycle pulse when a partial frame is discarded.
- o_drop  out  1  single-cycle pulse when a received byte is ignored.

## Operation
- States: GET_A, GET_B, GET_OP, EXEC, WAIT_TX. Reset state is GET_A.
- GET_A: i_rx_done captures the byte into o_alu_a and moves to GET_B.
- GET_B: i_rx_done captures the byte into o_alu_b and moves to GET_OP.
- GET_OP: i_rx_done captures i_rx_data[OP_WIDTH-1:0] into o_alu_op and moves to EXEC.
- EXEC: unconditional, one cycle.
  - o_tx_data <= i_alu_result.
  - o_tx_start <= 1.
  - Moves to WAIT_TX.
- WAIT_TX:
  - o_tx_start is cleared on the first edge after it was set.
  - i_tx_done moves the block to GET_A.
- Operand and opcode registers hold their values until overwritten by a new capture. They are not cleared at end of frame or on timeout.
- Bytes received in EXEC or WAIT_TX are ignored and o_drop pulses on the following cycle. If i_tx_done and i_rx_done coincide in WAIT_TX, the byte is dropped.
- Timeout counter:
  - Clears on every accepted byte and whenever the block is in GET_A, EXEC or WAIT_TX.
  - Increments each cycle in GET_B and GET_OP.
  - When it reaches TIMEOUT-1 with no i_rx_done that cycle, the block moves to GET_A and o_timeout pulses.
  - An i_rx_done arriving on the expiry cycle is accepted, and no timeout occurs.
  - The counter is sized to hold TIMEOUT-1 without wrap.
  - With TIMEOUT=0 the block never times out.

## Timing
- Reset values: o_alu_a=0, o_alu_b=0, o_alu_op=0, o_tx_data=0, o_tx_start=0, o_busy=0, o_timeout=0, o_drop=0. The counter is 0 and the state is GET_A.
- Reset assertion takes effect immediately, mid-frame included. Any partial frame is lost and o_tx_start falls immediately.
- Byte capture: a register updates on the edge where i_rx_done=1. The new value is visible the cycle after the i_rx_done pulse.
- Latency from the edge that samples the opcode (edge k):
  - Edge k+1 samples i_alu_result into o_tx_data and sets o_tx_start, visible the following cycle.
  - The ALU therefore has one full cycle to settle on the new a/b/op.
- o_tx_start is high for exactly one cycle, and o_tx_data is already valid in that cycle. o_tx_data is stable until the next EXEC.
- From i_tx_done in WAIT_TX, the block is in GET_A on the next cycle. A byte in that cycle is accepted as operand A.
- o_busy is registered from the state: high from the cycle after edge k until the cycle after i_tx_done.

## Test plan
- Normal frame, bench ALU model a+b: bytes 0x05, 0x03, 0x20, then i_tx_done.
  - Expect o_alu_a=0x05, o_alu_b=0x03, o_alu_op=0x20.
  - Expect o_tx_start for one cycle, exactly 2 cycles after the opcode pulse, with o_tx_data=0x08. The block returns to GET_A after i_tx_done.
- Timeout, TIMEOUT=16: send 0x11, then wait 16 cycles.
  - Expect a single o_timeout pulse and no o_tx_start.
  - Then frame 0x01, 0x02, 0x20 → o_alu_a=0x01, o_tx_data=0x03.
- Expiry race: i_rx_done lands exactly on the TIMEOUT-1 count in GET_B. Expect the byte to be accepted, no o_timeout and the state GET_OP.
- Drop: send 0x07 during WAIT_TX, including the cycle coincident with i_tx_done.
  - Expect an o_drop pulse in each case and o_alu_a unchanged.
  - The next frame completes correctly.
- Reset mid-frame: assert rst after operand B.
  - Expect all outputs back to 0 immediately and state GET_A.
  - Frame 0xFF, 0x01, 0x20 then yields o_tx_data=0x00 (8-bit wrap).
- Back-to-back: three frames with i_tx_done fed 10 cycles after each o_tx_start. Expect exactly three o_tx_start pulses with the correct results, and no o_drop.
